// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   mode_e         : operation select encoding carried on the 'sub' port
//   DEFAULT_BITS   : default operand/result width
//   DEFAULT_STAGES : default pipeline depth
package addsub_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } mode_e;

    localparam int DEFAULT_BITS   = 32;
    localparam int DEFAULT_STAGES = 4;

endpackage : addsub_pkg

// File: rtl/addsub_slice.sv
// Combinational W-bit ripple slice built from a chain of full-adder cells.
// The subtrahend arrives already inverted, so the slice only ever adds.
//   a, b   : W-bit operand slices
//   ci     : carry into bit 0 of the slice
//   s      : W-bit sum slice
//   co     : carry out of the slice MSB
//   msb_ci : carry into the slice MSB (used for signed overflow)
module addsub_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         msb_ci
);

    logic [W:0] c;

    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co     = c[W];
    assign msb_ci = c[W-1];

endmodule : addsub_slice

// File: rtl/pipe_addsub_nbits.sv
// Pipelined BITS-wide adder/subtractor split into STAGES carry-registered
// slices, with a valid/ready handshake on both sides.
//   clk, rst            : clock and asynchronous active-high reset
//   in_valid, in_ready  : input handshake (accept when both are 1)
//   a, b, ci, sub       : operands, carry/borrow-in, 0=add 1=subtract
//   out_valid, out_ready: output handshake (consume when both are 1)
//   s, co, ovf, zero    : result, carry-out (1 = no borrow), overflow, s==0
module pipe_addsub_nbits
    import addsub_pkg::*;
#(
    parameter int BITS   = DEFAULT_BITS,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            ci,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] s,
    output logic            co,
    output logic            ovf,
    output logic            zero
);

    localparam int W = (STAGES < 1) ? 1 : BITS / STAGES;

    generate
        if (STAGES < 1) begin : g_bad_stages
            $error("pipe_addsub_nbits: STAGES must be at least 1");
        end else if ((BITS % STAGES) != 0) begin : g_bad_split
            $error("pipe_addsub_nbits: BITS must be a multiple of STAGES");
        end
    endgenerate

    // One pipeline entry: operands still to be consumed by later stages,
    // the result slices finished so far, the ripple carry and final flags.
    typedef struct packed {
        logic [BITS-1:0] a;
        logic [BITS-1:0] bx;
        logic [BITS-1:0] s;
        logic            c;
        logic            ovf;
        logic            zero;
    } stage_t;

    stage_t            in_stage;
    stage_t            st_d [STAGES];
    stage_t            st_q [STAGES];
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [STAGES:0]   free;
    mode_e             op;

    assign op = mode_e'(sub);

    // Subtraction is a + ~b + !ci, so invert b and ci once at the entry.
    always_comb begin
        in_stage    = '0;
        in_stage.a  = a;
        in_stage.bx = (op == SUB) ? ~b : b;
        in_stage.c  = (op == SUB) ? ~ci : ci;
    end

    // free[k] means stage k can take a new entry this cycle: it is empty or
    // its current entry moves on. Evaluated from the output end backwards.
    always_comb begin
        free         = '0;
        adv          = '0;
        load         = '0;
        free[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]  = valid[k] & free[k+1];
            free[k] = ~valid[k] | adv[k];
        end
        load[0] = in_valid & free[0];
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
    end

    assign in_ready = free[0];

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            stage_t         src;
            stage_t         nxt;
            logic [W-1:0]   sl_s;
            logic           sl_co;
            logic           sl_msb_ci;

            if (k == 0) begin : g_first
                assign src = in_stage;
            end else begin : g_next
                assign src = st_q[k-1];
            end

            addsub_slice #(
                .W (W)
            ) u_slice (
                .a      (src.a[k*W +: W]),
                .b      (src.bx[k*W +: W]),
                .ci     (src.c),
                .s      (sl_s),
                .co     (sl_co),
                .msb_ci (sl_msb_ci)
            );

            // ovf/zero are only meaningful once the top slice is done; the
            // values from earlier stages are overwritten and never observed.
            always_comb begin
                nxt              = src;
                nxt.s[k*W +: W]  = sl_s;
                nxt.c            = sl_co;
                nxt.ovf          = sl_co ^ sl_msb_ci;
                nxt.zero         = (nxt.s == '0);
            end

            assign st_d[k] = nxt;
        end
    endgenerate

    // NOTE: state registers use non-blocking assignments so every stage
    // samples its predecessor's old value on the same edge.
    // NOTE: the data registers are reset along with the valid bits because
    // the outputs are required to read 0 during reset, not just out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    valid[k] <= 1'b1;
                    st_q[k]  <= st_d[k];
                end else if (adv[k]) begin
                    valid[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = valid[STAGES-1];
    assign s         = st_q[STAGES-1].s;
    assign co        = st_q[STAGES-1].c;
    assign ovf       = st_q[STAGES-1].ovf;
    assign zero      = st_q[STAGES-1].zero;

endmodule : pipe_addsub_nbits

// File: tb/tb_pipe_addsub_nbits.sv
// Scoreboard bench for pipe_addsub_nbits (BITS=32, STAGES=4). The driver
// pushes a hand-computed expectation when an operation is accepted; the
// monitor pops and compares whenever a result is consumed.
module tb_pipe_addsub_nbits;
    import addsub_pkg::*;

    localparam int  BITS   = 32;
    localparam int  STAGES = 4;
    localparam time PERIOD = 10;
    localparam time LAT    = (STAGES - 1) * PERIOD + PERIOD / 2;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic            ci;
    logic            sub;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] s;
    logic            co;
    logic            ovf;
    logic            zero;

    pipe_addsub_nbits #(
        .BITS   (BITS),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct {
        logic [BITS-1:0] s;
        logic            co;
        logic            ovf;
        logic            zero;
        time             t_acc;
        bit              chk_lat;
    } exp_t;

    exp_t            sb[$];
    exp_t            mon_e;
    int              errors    = 0;
    int              checks    = 0;
    int              n_out     = 0;
    int              n_before  = 0;
    bit              lat_mode  = 1'b1;
    bit              held      = 1'b0;
    logic [BITS+2:0] held_val;

    initial begin
        clk = 1'b0;
        forever #(PERIOD / 2) clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Offer one operation and hold it until accepted; expectation is queued
    // on the accepting edge.
    task automatic send(input logic [BITS-1:0] av, input logic [BITS-1:0] bv,
                        input logic civ, input logic subv,
                        input logic [BITS-1:0] es, input logic eco,
                        input logic eovf, input logic ez);
        int budget;
        exp_t e;
        a        = av;
        b        = bv;
        ci       = civ;
        sub      = subv;
        in_valid = 1'b1;
        budget   = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            budget++;
            if (budget > 50) begin
                fail_now("send_timeout");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        e.s = es; e.co = eco; e.ovf = eovf; e.zero = ez;
        e.t_acc = $time; e.chk_lat = lat_mode;
        sb.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            budget++;
            if (budget > 100) begin
                fail_now("drain_timeout");
                sb.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: consume results, compare in order, verify latency and hold.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_stable", {co, ovf, zero, s}, held_val);
                check("hold_valid", out_valid, 1'b1);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    mon_e = sb.pop_front();
                    check("result", {co, ovf, zero, s},
                          {mon_e.co, mon_e.ovf, mon_e.zero, mon_e.s});
                    if (mon_e.chk_lat)
                        check("latency", $time - mon_e.t_acc, LAT);
                end
            end
            held     = out_valid && !out_ready;
            held_val = {co, ovf, zero, s};
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        sub       = ADD;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_outputs", {out_valid, co, ovf, zero, s}, '0);
        check("reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("release_in_ready", in_ready, 1'b1);

        // Boundary vectors, one at a time.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        drain();
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, ADD, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        drain();
        send(32'h0000_0005, 32'h0000_0007, 1'b0, SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        drain();
        send(32'h8000_0000, 32'h0000_0001, 1'b0, SUB, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        drain();

        // Back-to-back stream with out_ready held high.
        send(32'h0000_0001, 32'h0000_0002, 1'b1, ADD, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0000, 32'h0000_0000, 1'b0, ADD, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        send(32'h0000_000A, 32'h0000_000A, 1'b0, SUB, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        send(32'h0000_0000, 32'h0000_0000, 1'b1, SUB, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, ADD, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        send(32'h1234_5678, 32'h1111_1111, 1'b0, ADD, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
        send(32'h0000_FFFF, 32'h0000_0001, 1'b1, ADD, 32'h0001_0001, 1'b0, 1'b0, 1'b0);
        send(32'h0001_0000, 32'h0000_0001, 1'b1, SUB, 32'h0000_FFFE, 1'b1, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, ADD, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);
        drain();

        // Backpressure: fill the pipe, offer a fifth op that must be refused.
        lat_mode = 1'b0;
        out_ready = 1'b0;
        send(32'h0000_0001, 32'h0000_0001, 1'b0, ADD, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0003, 32'h0000_0004, 1'b1, ADD, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0064, 32'h0000_0001, 1'b0, SUB, 32'h0000_0063, 1'b1, 1'b0, 1'b0);
        send(32'hFFFF_FF00, 32'h0000_0100, 1'b0, ADD, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        a = 32'h0000_0002; b = 32'h0000_0003; ci = 1'b1; sub = SUB;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(32'h0000_0002, 32'h0000_0003, 1'b1, SUB, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        drain();

        // Reset with three operations in flight.
        send(32'h0000_0010, 32'h0000_0020, 1'b0, ADD, 32'h0000_0030, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0011, 32'h0000_0021, 1'b0, ADD, 32'h0000_0032, 1'b0, 1'b0, 1'b0);
        send(32'h0000_0012, 32'h0000_0022, 1'b0, ADD, 32'h0000_0034, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 check("inflight_valid", out_valid, 1'b1);
        #1 rst = 1'b1;
        sb.delete();
        #1;
        check("async_reset_outputs", {out_valid, co, ovf, zero, s}, '0);
        check("async_reset_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        n_before = n_out;
        repeat (10) @(negedge clk);
        check("no_output_after_reset", n_out, n_before);
        check("release_in_ready_2", in_ready, 1'b1);
        check("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_addsub_nbits
